// File: rtl/ram_port_arbiter_if.sv
// One requester port of ram_port_arbiter: request/lock/write bundle in, grant and read return out.
// master = requester side, slave = arbiter side.
interface ram_port_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          req;
    logic          lock;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (output req, lock, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, lock, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-port arbiter in front of the single-port 8-bit RAM: bus locking, 1-cycle read return,
// fixed priority with a port-1 starvation guard, or round-robin when ARB_RR_EN is defined.
module ram_port_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8
`ifndef ARB_RR_EN
    ,
    parameter int MAX_WAIT = 4
`endif
) (
    input  logic                clk,
    input  logic                rst,
    ram_port_arbiter_if.slave   p0,
    ram_port_arbiter_if.slave   p1,
    output logic [AW-1:0]       ram_addr,
    output logic [DW-1:0]       ram_data,
    output logic                ram_rden,
    output logic                ram_wren,
    input  logic [DW-1:0]       ram_q,
    output logic [1:0]          owner
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_P0   = 2'b01,
        OWN_P1   = 2'b10
    } owner_e;

    owner_e owner_q, owner_d;
    logic   g0, g1;
    logic   rvalid0_q, rvalid1_q;
    logic   rvalid0, rvalid1;

`ifdef ARB_RR_EN
    logic ptr_q, ptr_d;
`else
    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);
    logic [3:0] wait_q, wait_d;
`endif

    // A held lock is checked against the live lock input, so a dropped lock frees the bus this cycle.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        g0      = 1'b0;
        g1      = 1'b0;
        owner_d = owner_q;
`ifdef ARB_RR_EN
        ptr_d   = ptr_q;
`endif
        if (rst) begin
            g0 = 1'b0;
            g1 = 1'b0;
        end else if (owner_q == OWN_P0 && p0.lock) begin
            g0 = p0.req;
        end else if (owner_q == OWN_P1 && p1.lock) begin
            g1 = p1.req;
        end else begin
            if (p0.req && p1.req) begin
`ifdef ARB_RR_EN
                g0    = ~ptr_q;
                g1    = ptr_q;
                ptr_d = ~ptr_q;
`else
                if (wait_q == WAIT_MAX) g1 = 1'b1;
                else                    g0 = 1'b1;
`endif
            end else begin
                g0 = p0.req;
                g1 = p1.req;
            end
            if (g0 && p0.lock)      owner_d = OWN_P0;
            else if (g1 && p1.lock) owner_d = OWN_P1;
            else                    owner_d = OWN_NONE;
        end
    end

`ifndef ARB_RR_EN
    // Counts refused port-1 cycles, saturating so the guard stays armed until port 1 wins.
    always_comb begin
        wait_d = wait_q;
        if (!p1.req || g1)          wait_d = '0;
        else if (wait_q != WAIT_MAX) wait_d = wait_q + 4'd1;
    end
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q   <= OWN_NONE;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
`ifdef ARB_RR_EN
            ptr_q     <= 1'b0;
`else
            wait_q    <= '0;
`endif
        end else begin
            owner_q   <= owner_d;
            rvalid0_q <= g0 & ~p0.we;
            rvalid1_q <= g1 & ~p1.we;
`ifdef ARB_RR_EN
            ptr_q     <= ptr_d;
`else
            wait_q    <= wait_d;
`endif
        end
    end

    always_comb begin
        ram_addr = '0;
        ram_data = '0;
        ram_rden = 1'b0;
        ram_wren = 1'b0;
        if (g0) begin
            ram_addr = p0.addr;
            ram_data = p0.wdata;
            ram_rden = ~p0.we;
            ram_wren = p0.we;
        end else if (g1) begin
            ram_addr = p1.addr;
            ram_data = p1.wdata;
            ram_rden = ~p1.we;
            ram_wren = p1.we;
        end
    end

    // Gating with rst hides a read granted just before reset.
    assign rvalid0   = rvalid0_q & ~rst;
    assign rvalid1   = rvalid1_q & ~rst;

    assign p0.gnt    = g0;
    assign p1.gnt    = g1;
    assign p0.rvalid = rvalid0;
    assign p1.rvalid = rvalid1;
    assign p0.rdata  = rvalid0 ? ram_q : '0;
    assign p1.rdata  = rvalid1 ? ram_q : '0;
    assign owner     = owner_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: a rule-level model checked every cycle plus literal
// expectations for reset, write/read, conflict, lock, saturation and reset-during-read.
module tb_ram_port_arbiter;

    localparam int MAXW = 4;

    logic       clk;
    logic       rst;
    logic [7:0] ram_addr, ram_data, ram_q;
    logic       ram_rden, ram_wren;
    logic [1:0] owner;

    ram_port_arbiter_if #(.AW(8), .DW(8)) p0_if ();
    ram_port_arbiter_if #(.AW(8), .DW(8)) p1_if ();

    ram_port_arbiter u_dut (
        .clk      (clk),
        .rst      (rst),
        .p0       (p0_if),
        .p1       (p1_if),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ram_rden (ram_rden),
        .ram_wren (ram_wren),
        .ram_q    (ram_q),
        .owner    (owner)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM environment: registered read, write on the edge.
    logic [7:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        ram_q = 8'h00;
    end
    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_data;
        if (ram_rden) ram_q <= mem[ram_addr];
    end

    // Reference model: owner 0/1/2, refused-cycle count, round-robin preference, memory image.
    int         m_owner, m_wait, m_ptr;
    bit         m_valid = 1'b0;
    bit         m_rv0, m_rv1;
    logic [7:0] m_q0, m_q1;
    logic [7:0] m_mem [256];
    initial for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;

    always @(negedge clk) begin
        bit r0, r1, l0, l1, held, e0, e1;
        logic [7:0] ea, ed;
        bit ew, er;
        r0 = p0_if.req; r1 = p1_if.req; l0 = p0_if.lock; l1 = p1_if.lock;
        held = (m_owner == 1 && l0) || (m_owner == 2 && l1);
        e0 = 1'b0; e1 = 1'b0;
        if (rst) begin
            e0 = 1'b0; e1 = 1'b0;
        end else if (m_owner == 1 && l0) begin
            e0 = r0;
        end else if (m_owner == 2 && l1) begin
            e1 = r1;
        end else if (r0 && r1) begin
`ifdef ARB_RR_EN
            e1 = (m_ptr == 1); e0 = !e1;
`else
            e1 = (m_wait == MAXW); e0 = !e1;
`endif
        end else begin
            e0 = r0; e1 = r1;
        end
        ea = 8'h00; ed = 8'h00; ew = 1'b0; er = 1'b0;
        if (e0) begin ea = p0_if.addr; ed = p0_if.wdata; ew = p0_if.we; er = !p0_if.we; end
        if (e1) begin ea = p1_if.addr; ed = p1_if.wdata; ew = p1_if.we; er = !p1_if.we; end

        if (m_valid) begin
            check("m_p0_gnt", p0_if.gnt, e0);
            check("m_p1_gnt", p1_if.gnt, e1);
            check("m_ram_addr", ram_addr, ea);
            check("m_ram_data", ram_data, ed);
            check("m_ram_wren", ram_wren, ew);
            check("m_ram_rden", ram_rden, er);
            check("m_owner", owner, m_owner);
            check("m_p0_rvalid", p0_if.rvalid, m_rv0 && !rst);
            check("m_p1_rvalid", p1_if.rvalid, m_rv1 && !rst);
            check("m_p0_rdata", p0_if.rdata, (m_rv0 && !rst) ? m_q0 : 8'h00);
            check("m_p1_rdata", p1_if.rdata, (m_rv1 && !rst) ? m_q1 : 8'h00);
        end

        if (rst) begin
            m_owner = 0; m_wait = 0; m_ptr = 0; m_rv0 = 0; m_rv1 = 0; m_valid = 1'b1;
        end else begin
            m_rv0 = e0 && !p0_if.we;
            m_rv1 = e1 && !p1_if.we;
            if (m_rv0) m_q0 = m_mem[p0_if.addr];
            if (m_rv1) m_q1 = m_mem[p1_if.addr];
            if (ew) m_mem[ea] = ed;
            if (!held) begin
                if (r0 && r1) m_ptr = 1 - m_ptr;
                m_owner = (e0 && l0) ? 1 : (e1 && l1) ? 2 : 0;
            end
            if (!r1 || e1)          m_wait = 0;
            else if (m_wait < MAXW) m_wait = m_wait + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit port, input bit req, input bit lock, input bit we,
                         input logic [7:0] addr, input logic [7:0] wdata);
        if (port == 1'b0) begin
            p0_if.req = req; p0_if.lock = lock; p0_if.we = we; p0_if.addr = addr; p0_if.wdata = wdata;
        end else begin
            p1_if.req = req; p1_if.lock = lock; p1_if.we = we; p1_if.addr = addr; p1_if.wdata = wdata;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        drive(0, 1, 0, 0, 8'h00, 8'h00);
        drive(1, 1, 0, 0, 8'h01, 8'h00);
        tick();
        #2;
        check("rst_p0_gnt", p0_if.gnt, 0);
        check("rst_p1_gnt", p1_if.gnt, 0);
        check("rst_rden", ram_rden, 0);
        check("rst_wren", ram_wren, 0);
        check("rst_owner", owner, 2'b00);
        check("rst_rvalid", {p0_if.rvalid, p1_if.rvalid}, 2'b00);
        tick();
        rst = 1'b0;
        drive(1, 0, 0, 0, 8'h00, 8'h00);

        // p0 write 0x5A to 0x10, then read it back
        drive(0, 1, 0, 1, 8'h10, 8'h5A);
        #2;
        check("wr_p0_gnt", p0_if.gnt, 1);
        check("wr_wren", ram_wren, 1);
        check("wr_addr", ram_addr, 8'h10);
        check("wr_data", ram_data, 8'h5A);
        tick();
        drive(0, 1, 0, 0, 8'h10, 8'h00);
        #2;
        check("rd_rden", ram_rden, 1);
        tick();
        drive(0, 0, 0, 0, 8'h00, 8'h00);
        #2;
        check("rd_p0_rvalid", p0_if.rvalid, 1);
        check("rd_p0_rdata", p0_if.rdata, 8'h5A);
        tick();

        // p1 write 0xC3 to 0x20, then read it back
        drive(1, 1, 0, 1, 8'h20, 8'hC3);
        tick();
        drive(1, 1, 0, 0, 8'h20, 8'h00);
        tick();
        drive(1, 0, 0, 0, 8'h00, 8'h00);
        #2;
        check("rd_p1_rdata", p1_if.rdata, 8'hC3);
        tick();

        // both ports reading continuously
        drive(0, 1, 0, 0, 8'h10, 8'h00);
        drive(1, 1, 0, 0, 8'h20, 8'h00);
        for (int i = 0; i < 10; i++) begin
            #2;
`ifdef ARB_RR_EN
            check("rr_p1_gnt", p1_if.gnt, (i % 2) == 1);
`else
            check("fp_p1_gnt", p1_if.gnt, (i == 4 || i == 9));
`endif
            tick();
        end
        drive(0, 0, 0, 0, 8'h00, 8'h00);
        drive(1, 0, 0, 0, 8'h00, 8'h00);
        tick();

        // p1 locks the bus, idles, then releases
        drive(1, 1, 1, 1, 8'h30, 8'h77);
        #2;
        check("lk_p1_gnt", p1_if.gnt, 1);
        tick();
        drive(1, 0, 1, 0, 8'h00, 8'h00);
        drive(0, 1, 0, 0, 8'h30, 8'h00);
        for (int i = 0; i < 3; i++) begin
            #2;
            check("lk_p0_blocked", p0_if.gnt, 0);
            check("lk_owner", owner, 2'b10);
            tick();
        end
        drive(1, 0, 0, 0, 8'h00, 8'h00);
        #2;
        check("lk_release_p0_gnt", p0_if.gnt, 1);
        tick();
        drive(0, 0, 0, 0, 8'h00, 8'h00);
        #2;
        check("lk_owner_none", owner, 2'b00);
        check("lk_p0_rdata", p0_if.rdata, 8'h77);
        tick();

        // p0 lock while p1 waits past MAX_WAIT; release hands the bus to p1
        drive(0, 1, 1, 0, 8'h10, 8'h00);
        drive(1, 1, 0, 0, 8'h20, 8'h00);
        for (int i = 0; i < 6; i++) begin
            #2;
            check("sat_p1_blocked", p1_if.gnt, 0);
            tick();
        end
        drive(0, 1, 0, 0, 8'h10, 8'h00);
`ifndef ARB_RR_EN
        #2;
        check("sat_p1_gnt", p1_if.gnt, 1);
`endif
        tick();
        drive(0, 0, 0, 0, 8'h00, 8'h00);
        drive(1, 0, 0, 0, 8'h00, 8'h00);
        tick();

        // reset right after a granted p1 read
        drive(1, 1, 0, 0, 8'h20, 8'h00);
        #2;
        check("rr_p1_read_gnt", p1_if.gnt, 1);
        tick();
        drive(1, 0, 0, 0, 8'h00, 8'h00);
        rst = 1'b1;
        #2;
        check("rstrd_p1_rvalid", p1_if.rvalid, 0);
        check("rstrd_p1_rdata", p1_if.rdata, 8'h00);
        tick();
        #2;
        check("rstrd_p1_rvalid2", p1_if.rvalid, 0);
        rst = 1'b0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
